// File: rtl/pulse_emitter.sv
// Emits per-channel pulse bursts: count_i_in pulses of PULSE_CYCLES high / GAP_CYCLES low.
// First pulse is high the cycle after the start edge. No backpressure: start is ignored while not idle.
module pulse_emitter #(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] count_0_in,
    input  logic [3:0] count_1_in,
    input  logic [3:0] count_2_in,
    input  logic [3:0] count_3_in,
    output logic       pulse_0_out,
    output logic       pulse_1_out,
    output logic       pulse_2_out,
    output logic       pulse_3_out,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [3:0]       round;
    logic [3:0]       max_cnt;
    logic [7:0]       timer;
    logic [3:0][3:0]  cnt_q;
    logic [3:0]       pulse_q;

    logic [3:0][3:0]  cnt_in;
    logic [3:0]       in_max;
    logic [3:0]       next_round;
    logic [3:0]       first_mask;
    logic [3:0]       next_mask;

    assign cnt_in     = {count_3_in, count_2_in, count_1_in, count_0_in};
    assign next_round = round + 4'd1;

    always_comb begin
        in_max     = '0;
        first_mask = '0;
        next_mask  = '0;
        for (int i = 0; i < 4; i++) begin
            if (cnt_in[i] > in_max)
                in_max = cnt_in[i];
            first_mask[i] = (cnt_in[i] != 4'd0);
            next_mask[i]  = (cnt_q[i] >= next_round);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            round   <= '0;
            max_cnt <= '0;
            timer   <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_q   <= cnt_in;
                        max_cnt <= in_max;
                        round   <= 4'd1;
                        if (in_max == 4'd0) begin
                            state <= S_DONE;
                            timer <= '0;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_HIGH;
                            timer   <= PULSE_LD;
                            pulse_q <= first_mask;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (timer == 8'd0) begin
                        pulse_q <= '0;
                        if (round == max_cnt) begin
                            state <= S_DONE;
                            timer <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOW;
                            timer <= GAP_LD;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                S_LOW: begin
                    if (timer == 8'd0) begin
                        // Round count never exceeds max_cnt, so the 4-bit round cannot wrap.
                        state   <= S_HIGH;
                        round   <= next_round;
                        timer   <= PULSE_LD;
                        pulse_q <= next_mask;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_0_out = pulse_q[0];
    assign pulse_1_out = pulse_q[1];
    assign pulse_2_out = pulse_q[2];
    assign pulse_3_out = pulse_q[3];

endmodule

// File: tb/tb_pulse_emitter.sv
// Directed bench for pulse_emitter: default-timing instance plus a PULSE=3/GAP=2 instance.
module tb_pulse_emitter;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_a = 1'b0;
    logic            start_b = 1'b0;
    logic [3:0][3:0] ca = '0;
    logic [3:0][3:0] cb = '0;
    wire  [3:0]      pa;
    wire  [3:0]      pb;
    wire             busy_a, done_a, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pulse_emitter dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .count_0_in(ca[0]), .count_1_in(ca[1]), .count_2_in(ca[2]), .count_3_in(ca[3]),
        .pulse_0_out(pa[0]), .pulse_1_out(pa[1]), .pulse_2_out(pa[2]), .pulse_3_out(pa[3]),
        .busy(busy_a), .done(done_a)
    );

    pulse_emitter #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .count_0_in(cb[0]), .count_1_in(cb[1]), .count_2_in(cb[2]), .count_3_in(cb[3]),
        .pulse_0_out(pb[0]), .pulse_1_out(pb[1]), .pulse_2_out(pb[2]), .pulse_3_out(pb[3]),
        .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_p    [7];
    logic       exp_busy [7];
    logic       exp_done [7];
    int         edges [4];
    int         sums  [4];
    logic [3:0] prev;
    int         m, got, len_err, timeouts;
    int         pat_err, skew, busy_cnt, done_cnt, done_cyc, edges_b0, edges_b3;
    int         stray, high_cnt;
    logic       exp_hi;

    initial begin
        // ---- reset state ----
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_pulses", int'(pa), 0);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_done", int'(done_a), 0);
        chk("reset_b_pulses", int'(pb), 0);

        // ---- defaults, counts 3/0/1/2, start on first edge after release ----
        exp_p[0] = 4'b1101; exp_p[1] = 4'b0000; exp_p[2] = 4'b1001; exp_p[3] = 4'b0000;
        exp_p[4] = 4'b0001; exp_p[5] = 4'b0000; exp_p[6] = 4'b0000;
        exp_busy[0] = 1; exp_busy[1] = 1; exp_busy[2] = 1; exp_busy[3] = 1;
        exp_busy[4] = 1; exp_busy[5] = 0; exp_busy[6] = 0;
        exp_done[0] = 0; exp_done[1] = 0; exp_done[2] = 0; exp_done[3] = 0;
        exp_done[4] = 0; exp_done[5] = 1; exp_done[6] = 0;
        rst = 1'b1;
        ca = {4'd2, 4'd1, 4'd0, 4'd3};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ca = {4'hF, 4'hF, 4'hF, 4'hF};   // late input changes must not affect the burst
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            chk($sformatf("dir_pulses_c%0d", c + 1), int'(pa), int'(exp_p[c]));
            chk($sformatf("dir_busy_c%0d", c + 1), int'(busy_a), int'(exp_busy[c]));
            chk($sformatf("dir_done_c%0d", c + 1), int'(done_a), int'(exp_done[c]));
        end

        // ---- all counts zero ----
        ca = '0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("zero_pulses", int'(pa), 0);
        chk("zero_busy", int'(busy_a), 0);
        chk("zero_done", int'(done_a), 1);
        tick();
        chk("zero_done_clear", int'(done_a), 0);

        // ---- start held: relaunch on first idle cycle after done ----
        ca = {4'd0, 4'd0, 4'd0, 4'd1};
        start_a = 1'b1;
        tick();
        chk("held_c1_pulses", int'(pa), 1);
        tick();
        chk("held_c2_done", int'(done_a), 1);
        tick();
        chk("held_c3_idle_busy", int'(busy_a), 0);
        tick();
        chk("held_c4_relaunch", int'(pa), 1);
        chk("held_c4_busy", int'(busy_a), 1);
        start_a = 1'b0;
        tick();
        chk("held_c5_done", int'(done_a), 1);
        tick();

        // ---- PULSE=3 GAP=2, counts 15, mid-burst start ignored ----
        cb = {4'd15, 4'd15, 4'd15, 4'd15};
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        pat_err = 0; skew = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        edges_b0 = 0; edges_b3 = 0; prev = '0;
        for (int n = 1; n <= 100; n++) begin
            exp_hi = (n <= 73) && (((n - 1) % 5) < 3);
            if (pb[0] !== exp_hi) pat_err++;
            if (pb !== {4{pb[0]}}) skew++;
            if (busy_b) busy_cnt++;
            if (done_b) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (pb[0] && !prev[0]) edges_b0++;
            if (pb[3] && !prev[3]) edges_b3++;
            prev = pb;
            start_b = (n == 10);
            tick();
        end
        start_b = 1'b0;
        chk("long_pattern_errors", pat_err, 0);
        chk("long_channel_skew", skew, 0);
        chk("long_edges_ch0", edges_b0, 15);
        chk("long_edges_ch3", edges_b3, 15);
        chk("long_busy_cycles", busy_cnt, 73);
        chk("long_done_cycle", done_cyc, 74);
        chk("long_done_count", done_cnt, 1);

        // ---- loopback: 200 random bursts, rising edges mod 16 per channel ----
        for (int i = 0; i < 4; i++) begin edges[i] = 0; sums[i] = 0; end
        len_err = 0; timeouts = 0;
        for (int b = 0; b < 200; b++) begin
            m = 0;
            for (int i = 0; i < 4; i++) begin
                ca[i] = 4'($urandom_range(0, 15));
                sums[i] += int'(ca[i]);
                if (int'(ca[i]) > m) m = int'(ca[i]);
            end
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            prev = '0;
            got = 0;
            for (int n = 1; n <= 40; n++) begin
                for (int i = 0; i < 4; i++)
                    if (pa[i] && !prev[i]) edges[i]++;
                prev = pa;
                if (done_a) begin
                    got = n;
                    break;
                end
                tick();
            end
            if (got == 0) timeouts++;
            else if (got != ((m == 0) ? 1 : 2 * m)) len_err++;
            tick();
        end
        chk("loop_timeouts", timeouts, 0);
        chk("loop_length_errors", len_err, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("loop_nibble_ch%0d", i), edges[i] % 16, sums[i] % 16);

        // ---- reset during round 2 of a count-5 burst ----
        ca = {4'd0, 4'd0, 4'd0, 4'd5};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        chk("abort_round2_high", int'(pa), 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_pulses", int'(pa), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        tick();
        tick();
        rst = 1'b1;
        stray = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (pa != 4'd0 || busy_a || done_a) stray++;
        end
        chk("abort_no_activity", stray, 0);
        ca = {4'd0, 4'd0, 4'd0, 4'd2};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        prev = '0; edges[0] = 0; high_cnt = 0; got = 0;
        for (int n = 1; n <= 20; n++) begin
            if (pa[0] && !prev[0]) edges[0]++;
            if (pa[0]) high_cnt++;
            prev = pa;
            if (done_a && got == 0) got = n;
            tick();
        end
        chk("after_abort_edges", edges[0], 2);
        chk("after_abort_high_cycles", high_cnt, 2);
        chk("after_abort_done_cycle", got, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_emitter.md
PULSE_EMITTER -- requirements
Module: pulse_emitter

Interface
REQ-001 Parameter PULSE_CYCLES, default 1: high time of each emitted pulse in clk cycles (legal 1..255).
REQ-002 Parameter GAP_CYCLES, default 1: low time between consecutive pulses in clk cycles (legal 1..255).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 start  in  1  request to emit one burst; sampled on rising clk.
REQ-006 count_0_in..count_3_in  in  4 each  number of pulses to emit on channels 0..3.
REQ-007 pulse_0_out..pulse_3_out  out  1 each  emitted pulse trains, registered.
REQ-008 busy  out  1  burst in progress, registered.
REQ-009 done  out  1  one-cycle burst-complete strobe, registered.

Function
REQ-010 The block SHALL be the inverse of the team's pulse counter: a burst emits exactly count_i_in pulses on pulse_i_out, i = 0..3.
REQ-011 FSM states SHALL be IDLE, HIGH, LOW, DONE.
REQ-012 In IDLE, start=1 at a rising edge SHALL latch all four counts, set round=1, and enter HIGH, or enter DONE if all four counts are 0.
REQ-013 In IDLE, start=0 SHALL hold state; counts SHALL be ignored outside the start edge (later input changes do not affect a burst).
REQ-014 The burst SHALL run in rounds k = 1..M, where M = max of the latched counts.
REQ-015 In round k, pulse_i_out SHALL be 1 for exactly PULSE_CYCLES cycles iff latched count_i >= k, else 0.
REQ-016 All active channels SHALL rise and fall in the same cycles.
REQ-017 HIGH SHALL last PULSE_CYCLES cycles, then go to LOW if k < M, or to DONE if k = M.
REQ-018 LOW SHALL last GAP_CYCLES cycles with all pulse outputs 0, then increment round and go to HIGH.
REQ-019 Latency: pulses for round 1 SHALL be high in the first cycle after the start sampling edge.
REQ-020 Burst length from start edge to DONE entry SHALL be M*PULSE_CYCLES + (M-1)*GAP_CYCLES cycles.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 exactly while in HIGH or LOW, and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in HIGH, LOW and DONE; there is no queuing.
REQ-024 Start held continuously SHALL launch a new burst on the first IDLE cycle after DONE.
REQ-025 Round counter SHALL be 4 bits and never wrap; M <= 15.
REQ-026 Phase timer SHALL be 8 bits, reloaded on every state entry.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, round=0, timer=0, latched counts=0, all pulse_i_out=0, busy=0, done=0, regardless of clk.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no done strobe; no further pulses after reset release until a new start.
REQ-030 The first start SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-031 Defaults, counts 3/0/1/2, one-cycle start -> pulse_0 high in cycles 1,3,5; pulse_2 in cycle 1; pulse_3 in cycles 1,3; pulse_1 never; done in cycle 6; busy in cycles 1..5.
REQ-032 All counts 0, start -> no pulses, busy stays 0, done=1 in the cycle after the start edge.
REQ-033 PULSE_CYCLES=3, GAP_CYCLES=2, counts 15/15/15/15 -> 15 pulses per channel, each 3 cycles high with 2-cycle gaps, done after 73 cycles; a second start mid-burst has no effect.
REQ-034 Loopback into the pulse counter, random counts over 200 bursts -> counter nibbles equal the sum mod 16 of the emitted counts per channel.
REQ-035 rst pulled low during round 2 of a count-5 burst -> all outputs 0 immediately, no done; after release, a new start with count 2 emits exactly 2 pulses.
